// File: rtl/spec_free_list.sv
// Free list of physical register tags for a 4-wide rename stage.
// Circular buffer: up to four tags are handed out from the head and up to
// four released tags are pushed at the tail each cycle. Recovery reclaims
// every tag issued since the last push by snapping head back to the tail.
module spec_free_list #(
    parameter int SIZE_PHYSICAL_LOG = 6,
    parameter int FL_DEPTH          = 32,
    parameter int FL_DEPTH_LOG      = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         releasedValid0_i,
    input  logic                         releasedValid1_i,
    input  logic                         releasedValid2_i,
    input  logic                         releasedValid3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] releasedPhyMap3_i,
    input  logic                         recoverFlag_i,
    input  logic [2:0]                   numReq_i,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeTag0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeTag1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeTag2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeTag3_o,
    output logic                         stall_o,
    output logic [FL_DEPTH_LOG:0]        freeCnt_o,
    output logic                         overflow_o
);

    localparam int CW  = FL_DEPTH_LOG + 1;
    localparam int CW1 = CW + 1;

    logic [SIZE_PHYSICAL_LOG-1:0] buffer [FL_DEPTH];
    logic [FL_DEPTH_LOG-1:0]      head;
    logic [FL_DEPTH_LOG-1:0]      tail;
    logic [CW-1:0]                count;

    logic [3:0]                   lane_valid;
    logic [SIZE_PHYSICAL_LOG-1:0] lane_tag [4];
    logic [2:0]                   lane_ofs [4];
    logic [2:0]                   req_eff;
    logic [2:0]                   pop_cnt;
    logic [2:0]                   valid_cnt;
    logic [2:0]                   push_cnt;
    logic [CW1-1:0]               room;
    logic                         overflow_now;

    assign lane_valid  = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
    assign lane_tag[0] = releasedPhyMap0_i;
    assign lane_tag[1] = releasedPhyMap1_i;
    assign lane_tag[2] = releasedPhyMap2_i;
    assign lane_tag[3] = releasedPhyMap3_i;

    // Tags freshly pushed this cycle are not yet in the buffer, so the
    // head window only ever shows tags that were present before the edge.
    assign freeTag0_o = buffer[head];
    assign freeTag1_o = buffer[head + FL_DEPTH_LOG'(1)];
    assign freeTag2_o = buffer[head + FL_DEPTH_LOG'(2)];
    assign freeTag3_o = buffer[head + FL_DEPTH_LOG'(3)];
    assign freeCnt_o  = count;

    // Request qualification, lane compaction and capacity clamp.
    always_comb begin
        req_eff      = (numReq_i > 3'd4) ? 3'd0 : numReq_i;
        stall_o      = (CW'(req_eff) > count) || (recoverFlag_i && (req_eff != 3'd0));
        pop_cnt      = (!stall_o && !recoverFlag_i) ? req_eff : 3'd0;
        room         = CW1'(FL_DEPTH) - (CW1'(count) - CW1'(pop_cnt));
        valid_cnt    = 3'd0;
        for (int k = 0; k < 4; k++) begin
            lane_ofs[k] = valid_cnt;
            valid_cnt   = valid_cnt + {2'b00, lane_valid[k]};
        end
        overflow_now = 1'b0;
        push_cnt     = valid_cnt;
        // Lanes beyond the remaining capacity are the highest-numbered ones
        // because their compacted offsets are the largest.
        if (CW1'(valid_cnt) > room) begin
            overflow_now = 1'b1;
            push_cnt     = room[2:0];
        end
    end

    // Buffer writes, pointer/count update, sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                buffer[i] <= SIZE_PHYSICAL_LOG'(FL_DEPTH + i);
            end
            head       <= '0;
            tail       <= '0;
            count      <= CW'(FL_DEPTH);
            overflow_o <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_valid[k] && (lane_ofs[k] < push_cnt)) begin
                    buffer[tail + FL_DEPTH_LOG'(lane_ofs[k])] <= lane_tag[k];
                end
            end
            tail <= tail + FL_DEPTH_LOG'(push_cnt);
            if (recoverFlag_i) begin
                head  <= tail + FL_DEPTH_LOG'(push_cnt);
                count <= CW'(FL_DEPTH);
            end else begin
                head  <= head + FL_DEPTH_LOG'(pop_cnt);
                count <= count - CW'(pop_cnt) + CW'(push_cnt);
            end
            if (overflow_now) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule
